// File: rtl/mc_arb_pkg.sv
// Shared types and defaults for the multicore motion-search result arbiter.
// Imported by the arbiter top and its round-robin picker.
package mc_arb_pkg;

    localparam int N_CORES_DEF = 4;
    localparam int DW_DEF      = 32;

    localparam logic [DW_DEF-1:0] SAD_INIT = '1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

endpackage

// File: rtl/multicore_result_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        int pos;
        o_valid = 1'b0;
        o_idx   = '0;
        pos     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(i_ptr) + k;
            if (pos >= N) pos = pos - N;
            if (i_req[pos]) begin
                o_valid = 1'b1;
                o_idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/multicore_result_arbiter.sv
// Collects per-core SAD results round-robin and keeps the global minimum,
// with tie-break to the lower core index.
module multicore_result_arbiter
    import mc_arb_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int DW      = DW_DEF,
    parameter int IW      = $clog2(N_CORES)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [N_CORES-1:0]    core_flag,
    input  logic [N_CORES*DW-1:0] core_sad,
    input  logic [N_CORES*DW-1:0] core_coord,
    output logic [N_CORES-1:0]    core_ack,
    output logic [DW-1:0]         best_sad,
    output logic [DW-1:0]         best_coord,
    output logic [IW-1:0]         best_core,
    output logic                  busy,
    output logic                  done,
    output logic                  dup_err
);

    localparam logic [DW-1:0] L_SAD_INIT = {DW{SAD_INIT[0]}};

    state_t               r_state;
    logic [N_CORES-1:0]   r_ack;
    logic [N_CORES-1:0]   r_reported;
    logic [IW-1:0]        r_ptr;
    logic [DW-1:0]        r_best_sad;
    logic [DW-1:0]        r_best_coord;
    logic [IW-1:0]        r_best_core;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dup;

    logic                 w_valid;
    logic [IW-1:0]        w_idx;
    logic [IW-1:0]        w_ptr_nxt;
    logic [N_CORES-1:0]   w_elig;
    logic [N_CORES-1:0]   w_onehot;
    logic [N_CORES-1:0]   w_rep_nxt;
    logic [DW-1:0]        w_sad;
    logic [DW-1:0]        w_coord;
    logic                 w_better;

    // Masking by the live ack stops a still-high flag being served twice.
    assign w_elig = core_flag & ~r_ack;

    rr_pick #(
        .N  (N_CORES),
        .IW (IW)
    ) u_pick (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_onehot  = N_CORES'(1) << w_idx;
    assign w_rep_nxt = r_reported | w_onehot;
    assign w_sad     = core_sad[w_idx*DW +: DW];
    assign w_coord   = core_coord[w_idx*DW +: DW];
    assign w_ptr_nxt = (w_idx == IW'(N_CORES - 1)) ? '0 : w_idx + IW'(1);
    assign w_better  = (w_sad < r_best_sad) ||
                       ((w_sad == r_best_sad) && (w_idx < r_best_core));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_ack        <= '0;
            r_reported   <= '0;
            r_ptr        <= '0;
            r_best_sad   <= L_SAD_INIT;
            r_best_coord <= '0;
            r_best_core  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_dup        <= 1'b0;
        end else begin
            r_ack <= '0;
            if (start) begin
                r_state      <= COLLECT;
                r_reported   <= '0;
                r_ptr        <= '0;
                r_best_sad   <= L_SAD_INIT;
                r_best_coord <= '0;
                r_best_core  <= '0;
                r_busy       <= 1'b1;
                r_done       <= 1'b0;
                r_dup        <= 1'b0;
            end else if (r_state == COLLECT && w_valid) begin
                r_ack <= w_onehot;
                r_ptr <= w_ptr_nxt;
                if (r_reported[w_idx]) begin
                    r_dup <= 1'b1;
                end else begin
                    r_reported <= w_rep_nxt;
                    if (w_better) begin
                        r_best_sad   <= w_sad;
                        r_best_coord <= w_coord;
                        r_best_core  <= w_idx;
                    end
                    if (&w_rep_nxt) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign core_ack   = r_ack;
    assign best_sad   = r_best_sad;
    assign best_coord = r_best_coord;
    assign best_core  = r_best_core;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dup_err    = r_dup;

endmodule
